// File: rtl/booth_seq_mul_pkg.sv
// Shared types for the Booth sequential multiplier.
// FSM state encoding and Booth recoding op codes.
package booth_seq_mul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Booth recoding of {Q[0], q_1}
   localparam logic [1:0] BOOTH_NOP0 = 2'b00;
   localparam logic [1:0] BOOTH_ADD  = 2'b01;
   localparam logic [1:0] BOOTH_SUB  = 2'b10;
   localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/booth_seq_mul_adder.sv
// Adder/subtractor: sum_o = a_i + b_i (add_sub_i=0) or a_i - b_i (1).
// Ports: a_i, b_i, add_sub_i in; sum_o, carry_o, zero_o, overflow_o out.
module adder #(
   parameter int n = 8
) (
   input  logic [n-1:0] a_i,
   input  logic [n-1:0] b_i,
   input  logic         add_sub_i,
   output logic [n-1:0] sum_o,
   output logic         carry_o,
   output logic         zero_o,
   output logic         overflow_o
);

   logic [n-1:0] b_x;
   logic [n:0]   full;

   // Subtract as a + ~b + 1
   assign b_x  = b_i ^ {n{add_sub_i}};
   assign full = {1'b0, a_i} + {1'b0, b_x}
               + {{n{1'b0}}, add_sub_i};

   assign sum_o      = full[n-1:0];
   assign carry_o    = full[n];
   assign zero_o     = (sum_o == '0);
   assign overflow_o = (a_i[n-1] == b_x[n-1])
                    && (sum_o[n-1] != a_i[n-1]);

endmodule

// File: rtl/booth_seq_mul.sv
// Radix-2 Booth sequential multiplier, N+1 steps, 2N-bit product.
// Ports: clk, rst, flush, in_valid/in_ready, mul_signed, a, b, out_valid/out_ready, product, busy.
module booth_seq_mul
   import booth_seq_mul_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           mul_signed,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int W  = N + 2;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N);

   if (N < 2) begin : g_bad_n
      $error("booth_seq_mul: N must be >= 2");
   end

   state_e         state_q;
   logic [W-1:0]   acc_q, acc_d, acc_sel;
   logic [W-1:0]   m_q, m_ext;
   logic [N:0]     q_q, q_d, q_ext;
   logic           q1_q, q1_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] prod_q, prod_d;
   logic           in_ready_q, out_valid_q, busy_q;

   logic [1:0]     booth;
   logic           sub;
   logic [W-1:0]   sum;
   logic           add_unused_c, add_unused_z, add_unused_v;

   adder #(.n(W)) u_adder (
      .a_i        (acc_q),
      .b_i        (m_q),
      .add_sub_i  (sub),
      .sum_o      (sum),
      .carry_o    (add_unused_c),
      .zero_o     (add_unused_z),
      .overflow_o (add_unused_v)
   );

   always_comb begin
      m_ext = mul_signed ? {{2{a[N-1]}}, a}
                         : {2'b00, a};
      q_ext = mul_signed ? {b[N-1], b}
                         : {1'b0, b};
      booth = {q_q[0], q1_q};
      sub   = (booth == BOOTH_SUB);
      unique case (booth)
         BOOTH_ADD, BOOTH_SUB: acc_sel = sum;
         default:              acc_sel = acc_q;
      endcase
      // Arithmetic right shift of {A,Q,q_1}
      acc_d  = {acc_sel[W-1], acc_sel[W-1:1]};
      q_d    = {acc_sel[0], q_q[N:1]};
      q1_d   = q_q[0];
      cnt_d  = cnt_q + CW'(1);
      prod_d = {acc_d[N-2:0], q_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         m_q         <= '0;
         q_q         <= '0;
         q1_q        <= 1'b0;
         cnt_q       <= '0;
         prod_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  m_q        <= m_ext;
                  q_q        <= q_ext;
                  acc_q      <= '0;
                  q1_q       <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= ST_CALC;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_CALC: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               q1_q  <= q1_d;
               cnt_q <= cnt_d;
               if (cnt_q == LAST) begin
                  state_q     <= ST_DONE;
                  prod_q      <= prod_d;
                  out_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = prod_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Testbench for booth_seq_mul at N=4 and N=8.
// Directed corners plus random ops against an arithmetic model.
module tb_booth_seq_mul;

   logic clk = 1'b0;
   logic rst, flush;
   always #5 clk = ~clk;

   logic       iv4, ir4, sg4, ov4, or4, bz4;
   logic [3:0] a4, b4;
   logic [7:0] p4;

   logic        iv8, ir8, sg8, ov8, or8, bz8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int n_vec = 0;
   int n_err = 0;

   booth_seq_mul #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(iv4), .in_ready(ir4),
      .mul_signed(sg4), .a(a4), .b(b4),
      .out_valid(ov4), .out_ready(or4),
      .product(p4), .busy(bz4)
   );

   booth_seq_mul #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(iv8), .in_ready(ir8),
      .mul_signed(sg8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8),
      .product(p8), .busy(bz8)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   // Low 2n bits of the exact integer product
   function automatic logic [63:0] model(
      input int n, input logic s,
      input logic [63:0] a, input logic [63:0] b);
      longint av, bv, p, mask;
      av = longint'(a);
      bv = longint'(b);
      if (s && a[n-1]) av = av - (longint'(1) << n);
      if (s && b[n-1]) bv = bv - (longint'(1) << n);
      p    = av * bv;
      mask = (longint'(1) << (2 * n)) - 1;
      return 64'(p & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op on dut4, wait for result, hold back for hold cycles
   task automatic run4(input logic s, input logic [3:0] a,
                       input logic [3:0] b, input int hold);
      int k;
      logic [7:0] e, got;
      e = 8'(model(4, s, 64'(a), 64'(b)));
      chk("ir4_idle", 64'(ir4), 64'd1);
      sg4 = s; a4 = a; b4 = b; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      sg4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      chk("busy4", 64'(bz4), 64'd1);
      k = 0;
      while (!ov4 && k < 20) begin
         tick();
         k++;
      end
      chk("lat4", 64'(k), 64'd5);
      chk("p4", 64'(p4), 64'(e));
      got = p4;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_ov", 64'(ov4), 64'd1);
         chk("hold_p", 64'(p4), 64'(got));
         chk("hold_ir", 64'(ir4), 64'd0);
      end
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      chk("ov4_drop", 64'(ov4), 64'd0);
      chk("ir4_back", 64'(ir4), 64'd1);
   endtask

   task automatic run8(input logic s, input logic [7:0] a,
                       input logic [7:0] b);
      int k;
      logic [15:0] e;
      e = 16'(model(8, s, 64'(a), 64'(b)));
      sg8 = s; a8 = a; b8 = b; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      k = 0;
      while (!ov8 && k < 30) begin
         tick();
         k++;
      end
      chk("lat8", 64'(k), 64'd9);
      chk("p8", 64'(p8), 64'(e));
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
   endtask

   // Start an op on dut4 and stop it after steps CALC cycles
   task automatic start4(input int steps);
      sg4 = 1'b1; a4 = 4'h7; b4 = 4'h7; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      repeat (steps) tick();
   endtask

   initial begin
      int k;
      logic seen;
      rst = 1'b1; flush = 1'b0;
      iv4 = 0; sg4 = 0; a4 = 0; b4 = 0; or4 = 0;
      iv8 = 0; sg8 = 0; a8 = 0; b8 = 0; or8 = 0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ir4", 64'(ir4), 64'd1);
      chk("rst_ov4", 64'(ov4), 64'd0);
      chk("rst_bz4", 64'(bz4), 64'd0);
      chk("rst_p4", 64'(p4), 64'd0);
      chk("rst_ir8", 64'(ir8), 64'd1);
      chk("rst_p8", 64'(p8), 64'd0);

      // Directed corners
      run4(1'b1, 4'd3, 4'hE, 0);
      chk("3x-2", 64'(p4), 64'hFA);
      run4(1'b0, 4'hF, 4'hF, 0);
      chk("15x15", 64'(p4), 64'hE1);
      run4(1'b1, 4'h8, 4'h8, 0);
      chk("-8x-8", 64'(p4), 64'h40);
      run4(1'b1, 4'h8, 4'h7, 10);
      chk("-8x7", 64'(p4), 64'hC8);

      // Reset mid-calculation
      start4(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_ir", 64'(ir4), 64'd1);
      chk("mrst_ov", 64'(ov4), 64'd0);
      chk("mrst_bz", 64'(bz4), 64'd0);
      chk("mrst_p", 64'(p4), 64'd0);
      run4(1'b1, 4'h5, 4'hD, 0);
      chk("5x-3", 64'(p4), 64'hF1);

      // Flush mid-calculation
      start4(3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_ir", 64'(ir4), 64'd1);
      chk("fl_bz", 64'(bz4), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (ov4) seen = 1'b1;
         tick();
      end
      chk("fl_noval", 64'(seen), 64'd0);
      run4(1'b0, 4'd5, 4'd3, 0);
      chk("5x3", 64'(p4), 64'h0F);

      // Flush while holding a result
      sg4 = 1'b0; a4 = 4'd2; b4 = 4'd3; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      k = 0;
      while (!ov4 && k < 20) begin
         tick();
         k++;
      end
      chk("dfl_ov", 64'(ov4), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("dfl_drop", 64'(ov4), 64'd0);
      chk("dfl_p", 64'(p4), 64'h06);

      // Random ops
      for (int i = 0; i < 200; i++)
         run4(1'($urandom), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 2)));
      for (int i = 0; i < 1000; i++)
         run8(1'($urandom), 8'($urandom), 8'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
